pea_invoke_scheduler: RTL

Sequences firings of the PEA top module under its CFDF mode schedule (SETUP_INSTR -> INSTR -> OUTPUT -> INSTR ...), replacing hand-driven invoke/next_instr stimulus. Per firing it waits for the PEA enable check, issues a one-cycle invoke, and waits for FC, with a timeout. After an OUTPUT firing it drains the paired result/status output FIFOs to a host-side valid/ready port. Sits between the host/test harness and PEA_top_module_1, PEA_enable and the two 32-bit output FIFOs.

---
 rtl/pea_invoke_scheduler_if.sv | 42 ++++
 rtl/pea_invoke_scheduler.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pea_invoke_scheduler_if.sv
// rtl/pea_invoke_scheduler_if.sv - host, PEA and output-FIFO signal bundle for pea_invoke_scheduler
interface pea_invoke_scheduler_if #(
    parameter int buffer_size_out = 32
);
    localparam int POP_W = $clog2(buffer_size_out);

    logic             go;
    logic             abort;
    logic             enable;
    logic             FC;
    logic [POP_W-1:0] result_pop_out;
    logic [POP_W-1:0] status_pop_out;
    logic [31:0]      data_out_fifo1_result;
    logic [31:0]      data_out_fifo2_status;
    logic             res_ready;
    logic             invoke;
    logic [1:0]       next_instr;
    logic             rd_en_result;
    logic             rd_en_status;
    logic             res_valid;
    logic [31:0]      res_data;
    logic [31:0]      sts_data;
    logic             busy;
    logic             err_timeout;
    logic [15:0]      fire_count;

    // Host / harness side: drives requests, PEA status and FIFO state.
    modport master (
        output go, abort, enable, FC, result_pop_out, status_pop_out,
               data_out_fifo1_result, data_out_fifo2_status, res_ready,
        input  invoke, next_instr, rd_en_result, rd_en_status, res_valid,
               res_data, sts_data, busy, err_timeout, fire_count
    );

    // Scheduler side.
    modport slave (
        input  go, abort, enable, FC, result_pop_out, status_pop_out,
               data_out_fifo1_result, data_out_fifo2_status, res_ready,
        output invoke, next_instr, rd_en_result, rd_en_status, res_valid,
               res_data, sts_data, busy, err_timeout, fire_count
    );
endinterface

// File: rtl/pea_invoke_scheduler.sv
// rtl/pea_invoke_scheduler.sv - CFDF firing sequencer for the PEA with output FIFO drain; optional fire counter under PEA_SCHED_FIRE_CNT_EN
// PEA input word width (16) is documentation only and does not appear in the logic.
module pea_invoke_scheduler #(
    parameter int FC_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    pea_invoke_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        INVOKE,
        ARM,
        WAIT_FC,
        ADVANCE,
        DRAIN_RD,
        DRAIN_HOLD
    } state_t;

    typedef enum logic [1:0] {
        M_SETUP  = 2'b00,
        M_INSTR  = 2'b01,
        M_OUTPUT = 2'b10
    } mode_t;

    localparam logic [15:0] TO_LAST = 16'(FC_TIMEOUT - 1);

    state_t      state;
    mode_t       mode;
    logic        invoke_q;
    logic        rd_en_q;
    logic        res_valid_q;
    logic [31:0] res_q;
    logic [31:0] sts_q;
    logic        busy_q;
    logic        err_q;
    logic [15:0] fc_cnt;

    // Firing sequencer and drain engine; all outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mode        <= M_SETUP;
            invoke_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_q       <= 32'd0;
            sts_q       <= 32'd0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            fc_cnt      <= 16'd0;
        end else begin
            invoke_q <= 1'b0;
            rd_en_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        state  <= CHECK;
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                    end
                end
                CHECK: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (bus.enable) begin
                        state    <= INVOKE;
                        invoke_q <= 1'b1;
                    end
                end
                INVOKE: begin
                    state <= ARM;
                end
                ARM: begin
                    // FC from the invoke cycle is not trusted; the count starts fresh.
                    fc_cnt <= 16'd0;
                    state  <= WAIT_FC;
                end
                WAIT_FC: begin
                    if (bus.FC) begin
                        state <= ADVANCE;
                    end else if (fc_cnt == TO_LAST) begin
                        err_q  <= 1'b1;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        fc_cnt <= fc_cnt + 16'd1;
                    end
                end
                ADVANCE: begin
                    case (mode)
                        M_SETUP:  mode <= M_INSTR;
                        M_INSTR:  mode <= M_OUTPUT;
                        M_OUTPUT: mode <= M_INSTR;
                        default:  mode <= M_SETUP;
                    endcase
                    if (mode == M_OUTPUT) begin
                        state <= DRAIN_RD;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                DRAIN_RD: begin
                    // Pop only when both FIFOs hold a word so result/status stay paired.
                    if (bus.result_pop_out == '0 || bus.status_pop_out == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (!res_valid_q) begin
                        rd_en_q <= 1'b1;
                        state   <= DRAIN_HOLD;
                    end
                end
                DRAIN_HOLD: begin
                    // First cycle here is the pop cycle; FIFO data is valid one cycle later.
                    if (!rd_en_q) begin
                        if (!res_valid_q) begin
                            res_q       <= bus.data_out_fifo1_result;
                            sts_q       <= bus.data_out_fifo2_status;
                            res_valid_q <= 1'b1;
                        end else if (bus.res_ready) begin
                            res_valid_q <= 1'b0;
                            state       <= DRAIN_RD;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PEA_SCHED_FIRE_CNT_EN
    logic [15:0] fire_cnt;

    // Completed firings; only ADVANCE counts, so timeouts and aborts are excluded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fire_cnt <= 16'd0;
        end else if (state == ADVANCE) begin
            fire_cnt <= fire_cnt + 16'd1;
        end
    end

    assign bus.fire_count = fire_cnt;
`else
    assign bus.fire_count = 16'd0;
`endif

    assign bus.invoke       = invoke_q;
    assign bus.next_instr   = mode;
    assign bus.rd_en_result = rd_en_q;
    assign bus.rd_en_status = rd_en_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_q;
    assign bus.sts_data     = sts_q;
    assign bus.busy         = busy_q;
    assign bus.err_timeout  = err_q;

endmodule
